sram_1p_rr_arbiter: RTL and testbench

//  Shares one single-port SRAM (active-low cen/wen, read latency 1) between NREQ requesters.

---
 rtl/sram_1p_rr_arbiter_if.sv | 19 +
 rtl/sram_1p_rr_arbiter.sv | 105 ++++++++++
 tb/tb_sram_1p_rr_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_1p_rr_arbiter_if.sv
// Requester-side bus of sram_1p_rr_arbiter: flattened per-requester access fields,
// one-hot grant, and the shared read-return path.
interface sram_1p_rr_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WWORD = 32,
    parameter int WADDR = 5
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WADDR-1:0] addr;
    logic [NREQ*WWORD-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rvalid;
    logic [WWORD-1:0]      rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_1p_rr_arbiter.sv
// Round-robin arbiter with per-requester lock sharing one single-port SRAM (latency 1).
// Define SRAM_ARB_RDREG_EN to register rdata/rvalid once more (read latency 2).
module sram_1p_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int WWORD = 32,
    parameter int WADDR = 5
) (
    input  logic             clk,
    input  logic             rstn,
    sram_1p_rr_arbiter_if.slave bus,
    output logic             sram_cen,
    output logic             sram_wen,
    output logic [WADDR-1:0] sram_a,
    output logic [WWORD-1:0] sram_d,
    input  logic [WWORD-1:0] sram_q
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic             own_v;
    logic [NREQ-1:0]  rd_pend;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    ptr_next;
    logic             any_gnt;
    logic [NREQ-1:0]  gnt;
    logic [WADDR-1:0] a_hold;
    logic [WWORD-1:0] d_hold;

    // Scan from highest offset down so the first requester at or after ptr wins.
    always_comb begin
        gnt     = '0;
        sel     = '0;
        cand    = '0;
        any_gnt = 1'b0;
        if (rstn) begin
            if (own_v && bus.req[owner]) begin
                any_gnt = 1'b1;
                sel     = owner;
            end else begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    cand = PW'((int'(ptr) + k) % NREQ);
                    if (bus.req[cand]) begin
                        any_gnt = 1'b1;
                        sel     = cand;
                    end
                end
            end
            if (any_gnt) gnt[sel] = 1'b1;
        end
    end

    assign ptr_next = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);

    assign sram_cen = ~any_gnt;
    assign sram_wen = any_gnt ? ~bus.we[sel] : 1'b1;
    assign sram_a   = any_gnt ? bus.addr[sel*WADDR +: WADDR]  : a_hold;
    assign sram_d   = any_gnt ? bus.wdata[sel*WWORD +: WWORD] : d_hold;
    assign bus.gnt  = gnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr     <= '0;
            owner   <= '0;
            own_v   <= 1'b0;
            rd_pend <= '0;
            a_hold  <= '0;
            d_hold  <= '0;
        end else begin
            rd_pend <= gnt & ~bus.we;
            if (any_gnt) begin
                a_hold <= bus.addr[sel*WADDR +: WADDR];
                d_hold <= bus.wdata[sel*WWORD +: WWORD];
                if (bus.lock[sel]) begin
                    own_v <= 1'b1;
                    owner <= sel;
                end else begin
                    own_v <= 1'b0;
                    ptr   <= ptr_next;
                end
            end else begin
                own_v <= 1'b0;
            end
        end
    end

`ifdef SRAM_ARB_RDREG_EN
    logic [NREQ-1:0]  rv_q;
    logic [WWORD-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (!rstn) rv_q <= '0;
        else       rv_q <= rd_pend;
        rd_q <= sram_q;
    end

    assign bus.rvalid = rstn ? rv_q : '0;
    assign bus.rdata  = rd_q;
`else
    // Gated by rstn so a read in flight when reset arrives never reports valid.
    assign bus.rvalid = rstn ? rd_pend : '0;
    assign bus.rdata  = sram_q;
`endif
endmodule

// File: tb/tb_sram_1p_rr_arbiter.sv
// Directed bench for sram_1p_rr_arbiter (NREQ=2) with a behavioural single-port SRAM.
// Build with SRAM_ARB_RDREG_EN defined to check the latency-2 read path.
module tb_sram_1p_rr_arbiter;
    localparam int NREQ  = 2;
    localparam int WWORD = 32;
    localparam int WADDR = 5;
`ifdef SRAM_ARB_RDREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             sram_cen;
    logic             sram_wen;
    logic [WADDR-1:0] sram_a;
    logic [WWORD-1:0] sram_d;
    logic [WWORD-1:0] sram_q;
    logic [WWORD-1:0] mem [0:31];
    int               checks = 0;
    int               errors = 0;

    sram_1p_rr_arbiter_if #(.NREQ(NREQ), .WWORD(WWORD), .WADDR(WADDR)) bus ();

    sram_1p_rr_arbiter #(.NREQ(NREQ), .WWORD(WWORD), .WADDR(WADDR)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.req   = r;
        bus.we    = w;
        bus.lock  = l;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 32'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            checks++; if (bus.gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt c%0d: got %b expected 00", c, bus.gnt); end
            checks++; if (sram_cen !== 1'b1) begin errors++; $display("[TB] FAIL reset_cen c%0d: got %b expected 1", c, sram_cen); end
            checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid c%0d: got %b expected 00", c, bus.rvalid); end
        end
        step();
        rstn = 1'b1;
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("[TB] FAIL reset_first_gnt: got %b expected 01", bus.gnt); end
        step();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_write_read();
        do_reset();
        step();
        drive(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("[TB] FAIL wr_gnt: got %b expected 01", bus.gnt); end
        checks++; if (sram_cen !== 1'b0 || sram_wen !== 1'b0) begin errors++; $display("[TB] FAIL wr_cen_wen: got %b%b expected 00", sram_cen, sram_wen); end
        checks++; if (sram_a !== 5'd5) begin errors++; $display("[TB] FAIL wr_addr: got %0d expected 5", sram_a); end
        checks++; if (sram_d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_data: got %h expected deadbeef", sram_d); end
        step();
        drive(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 32'd0, 32'd0);
        #1;
        checks++; if (bus.gnt !== 2'b01 || sram_wen !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt_wen: got %b/%b expected 01/1", bus.gnt, sram_wen); end
        checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("[TB] FAIL wr_no_rvalid: got %b expected 00", bus.rvalid); end
        for (int c = 1; c <= LAT; c++) begin
            step();
            drive(2'b00, 2'b00, 2'b00, 5'd9, 5'd9, 32'd0, 32'd0);
            #1;
            checks++; if (sram_cen !== 1'b1 || sram_a !== 5'd5) begin errors++; $display("[TB] FAIL idle_hold: got cen=%b a=%0d expected cen=1 a=5", sram_cen, sram_a); end
            if (c == LAT) begin
                checks++; if (bus.rvalid !== 2'b01) begin errors++; $display("[TB] FAIL rd_rvalid: got %b expected 01", bus.rvalid); end
                checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_data: got %h expected deadbeef", bus.rdata); end
            end else begin
                checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rd_early_rvalid: got %b expected 00", bus.rvalid); end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [4:0]  exp_a;
        do_reset();
        for (int k = 0; k < 6 + LAT; k++) begin
            step();
            if (k < 6) drive(2'b11, 2'b00, 2'b00, 5'(10 + (k + 1) / 2), 5'(20 + k / 2), 32'd0, 32'd0);
            else       drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
            #1;
            if (k < 6) begin
                exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (bus.gnt !== exp_g) begin errors++; $display("[TB] FAIL cont_gnt k%0d: got %b expected %b", k, bus.gnt, exp_g); end
            end
            if (k >= LAT) begin
                exp_g = ((k - LAT) % 2 == 0) ? 2'b01 : 2'b10;
                exp_a = ((k - LAT) % 2 == 0) ? 5'(10 + (k - LAT) / 2) : 5'(20 + (k - LAT - 1) / 2);
                checks++; if (bus.rvalid !== exp_g) begin errors++; $display("[TB] FAIL cont_rvalid k%0d: got %b expected %b", k, bus.rvalid, exp_g); end
                checks++; if (bus.rdata !== 32'hA0000000 + 32'(exp_a)) begin errors++; $display("[TB] FAIL cont_rdata k%0d: got %h expected %h", k, bus.rdata, 32'hA0000000 + 32'(exp_a)); end
            end else begin
                checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("[TB] FAIL cont_rvalid_early k%0d: got %b expected 00", k, bus.rvalid); end
            end
        end
    endtask

    task automatic test_lock_burst();
        do_reset();
        step();
        drive(2'b01, 2'b01, 2'b00, 5'd7, 5'd0, 32'h12345678, 32'd0);
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("[TB] FAIL lock_pre_gnt: got %b expected 01", bus.gnt); end
        for (int k = 0; k < 4 + LAT; k++) begin
            step();
            if (k < 4)       drive(2'b11, 2'b00, 2'b10, 5'd15, 5'(k), 32'd0, 32'd0);
            else if (k == 4) drive(2'b01, 2'b00, 2'b00, 5'd15, 5'd0, 32'd0, 32'd0);
            else             drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
            #1;
            if (k < 4) begin
                checks++; if (bus.gnt !== 2'b10) begin errors++; $display("[TB] FAIL lock_gnt k%0d: got %b expected 10", k, bus.gnt); end
            end else if (k == 4) begin
                checks++; if (bus.gnt !== 2'b01) begin errors++; $display("[TB] FAIL lock_release_gnt: got %b expected 01", bus.gnt); end
            end
            if (k >= LAT && k - LAT < 4) begin
                checks++; if (bus.rvalid !== 2'b10) begin errors++; $display("[TB] FAIL lock_rvalid k%0d: got %b expected 10", k, bus.rvalid); end
                checks++; if (bus.rdata !== 32'hA0000000 + 32'(k - LAT)) begin errors++; $display("[TB] FAIL lock_rdata k%0d: got %h expected %h", k, bus.rdata, 32'hA0000000 + 32'(k - LAT)); end
            end
        end
        step();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            drive(2'b10, 2'b00, 2'b10, 5'd0, 5'(4 + k), 32'd0, 32'd0);
            #1;
            checks++; if (bus.gnt !== 2'b10) begin errors++; $display("[TB] FAIL lock_solo_gnt k%0d: got %b expected 10", k, bus.gnt); end
        end
        step();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        drive(2'b11, 2'b00, 2'b00, 5'd0, 5'd6, 32'd0, 32'd0);
        #1;
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("[TB] FAIL lock_ptr_kept: got %b expected 10", bus.gnt); end
        step();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        step();
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd3, 32'd0, 32'd0);
        #1;
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("[TB] FAIL mid_gnt: got %b expected 10", bus.gnt); end
        step();
        rstn = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("[TB] FAIL mid_rvalid_n1: got %b expected 00", bus.rvalid); end
        step();
        rstn = 1'b1;
        #1;
        checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("[TB] FAIL mid_rvalid_n2: got %b expected 00", bus.rvalid); end
        step();
        drive(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("[TB] FAIL mid_state_cleared: got %b expected 01", bus.gnt); end
        step();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA0000000 + 32'(i);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        test_reset();
        test_write_read();
        test_contention();
        test_lock_burst();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
